// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master round-robin arbiter in front of a single-ported data RAM.
//   M0 is the core data port, M1 the loader/debug master.
//
//   - The grant is decoded from a state register, so a request seen in IDLE
//     during cycle N is granted in cycle N+1.
//   - Read data is captured at the end of the grant cycle, so rvalid/rdata
//     appear in cycle N+2.
//   - While a master is granted, the RAM bus is a straight pass-through of
//     that master's address, write data and write enable.
//
//   Optional feature, enabled by defining DMEM_ARB_LOCK_EN:
//   m0_lock/m1_lock let the granted master keep ownership of the RAM across
//   back-to-back accesses. The other master is locked out meanwhile.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active-low

  // M0: core data port
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  // M1: loader / debug master
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif

  // RAM side
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE0 = 3'd1;
  localparam logic [2:0] ST_SERVE1 = 3'd2;
`ifdef DMEM_ARB_LOCK_EN
  localparam logic [2:0] ST_LOCK0  = 3'd3;
  localparam logic [2:0] ST_LOCK1  = 3'd4;
`endif

  logic [2:0] state;
  logic [2:0] state_nxt;

  // Master that most recently completed an access.
  // 1 = M1, so M0 wins the first tie after reset.
  logic       last;
  logic       last_nxt;

  // Lock requests, seen only while the corresponding master is being served
  // or is holding the lock.
  logic       lock0;
  logic       lock1;

`ifdef DMEM_ARB_LOCK_EN
  assign lock0 = m0_lock;
  assign lock1 = m1_lock;
`else
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant decode.
  // A SERVE slot only becomes a real access if the master is still
  // requesting. A request dropped before its grant is abandoned: it gets no
  // grant and causes no RAM side effect.
  // ---------------------------------------------------------------------------
  logic gnt0;
  logic gnt1;

  assign gnt0   = (state == ST_SERVE0) && m0_req;
  assign gnt1   = (state == ST_SERVE1) && m1_req;
  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Next-state selection: round-robin in IDLE, hand-over or lock after a
  // serve slot.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default on entry.
    // Otherwise a path that skips the assignment infers a latch.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = last ? ST_SERVE0 : ST_SERVE1;
        end else if (m0_req) begin
          state_nxt = ST_SERVE0;
        end else if (m1_req) begin
          state_nxt = ST_SERVE1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SERVE0: begin
`ifdef DMEM_ARB_LOCK_EN
        if (lock0) begin
          state_nxt = ST_LOCK0;
        end else
`endif
        if (m1_req) begin
          state_nxt = ST_SERVE1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_SERVE1: begin
`ifdef DMEM_ARB_LOCK_EN
        if (lock1) begin
          state_nxt = ST_LOCK1;
        end else
`endif
        if (m0_req) begin
          state_nxt = ST_SERVE0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

`ifdef DMEM_ARB_LOCK_EN
      // The owner keeps the RAM.
      // The other master's request is ignored until the lock is released.
      ST_LOCK0: begin
        if (m0_req) begin
          state_nxt = ST_SERVE0;
        end else if (!lock0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOCK0;
        end
      end

      ST_LOCK1: begin
        if (m1_req) begin
          state_nxt = ST_SERVE1;
        end else if (!lock1) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOCK1;
        end
      end
`endif

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin pointer: remember who completed the access this cycle.
  always_comb begin
    last_nxt = last;
    if (gnt0) begin
      last_nxt = 1'b0;
    end else if (gnt1) begin
      last_nxt = 1'b1;
    end
  end

  // Lock signals are only consumed in SERVE/LOCK states.
  // Without the feature they are tied off and the LOCK states never exist.
  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    // Every register then samples pre-edge values regardless of block order.
    if (!reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // RAM bus mux.
  // The bus is driven only during a real access, and is zero otherwise.
  // It is purely combinational from the state register and the granted
  // master's inputs. So a write in a serve cycle that coincides with reset
  // still reaches the RAM.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt0) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_wd   = m0_wdata;
    end else if (gnt1) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_wd   = m1_wdata;
    end
  end

  // M0 read return: capture RAM data at the end of a granted read cycle.
  // The data is held until the next read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0 && !m0_we;
      if (gnt0 && !m0_we) begin
        m0_rdata <= mem_rd;
      end
    end
  end

  // M1 read return, same behaviour as M0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m1_rvalid <= gnt1 && !m1_we;
      if (gnt1 && !m1_we) begin
        m1_rdata <= mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with a 64-word RAM model.
//   Stimulus:
//     - a vector table with constant expectations
//     - hand-written reset sequences
//     - a randomized phase
//   Every cycle is also compared against a slot-level reference model.
//   The lock-ownership sequence runs only when DMEM_ARB_LOCK_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
`ifdef DMEM_ARB_LOCK_EN
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
`endif
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // RAM behind the arbiter.
  // Reads are combinational; a write commits at the clock edge.
  logic [31:0] ram [64] = '{default: '0};
  assign mem_rd = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wd;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, written in terms of access slots.
  //   mc    = master the arbiter committed to serve in the coming cycle
  //           (-1 = free slot)
  //   mlock = master holding exclusive ownership (-1 = none)
  //   mlast = master that most recently completed an access
  // ---------------------------------------------------------------------------
  int          mc = -1, mlock = -1, mlast = 1;
  logic [31:0] mram [64];
  logic        mrv [2];
  logic [31:0] mrd [2];
  logic        eg [2];      // model grant this cycle (drives random stimulus)
  logic        act_g0, act_g1;

  typedef struct packed {
    logic        rn;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        chk;
    logic        e_g0, e_g1, e_we, e_rv0, e_rv1;
    logic [31:0] e_rd0;
  } vec_t;

  function automatic vec_t v(input logic rn, r0, w0, input logic [31:0] a0, d0,
                             input logic r1, w1, input logic [31:0] a1, d1,
                             input logic g0, g1, we, rv0, rv1, input logic [31:0] rd0);
    vec_t t;
    t = '{rn: rn, r0: r0, w0: w0, a0: a0, d0: d0, r1: r1, w1: w1, a1: a1, d1: d1,
          chk: 1'b1, e_g0: g0, e_g1: g1, e_we: we, e_rv0: rv0, e_rv1: rv1, e_rd0: rd0};
    return t;
  endfunction

  // Drive one cycle's inputs, compare away from the active edge, then advance
  // the model across the coming edge.
  task automatic run_cycle(input vec_t t);
    logic        rq [2], wq [2], lk [2], nrv [2];
    logic [31:0] aq [2], dq [2];
    logic        ewe;
    logic [31:0] ea, ed;
    int          y;

    @(negedge clk);
    rst = t.rn;
    m0_req = t.r0; m0_we = t.w0; m0_addr = t.a0; m0_wdata = t.d0;
    m1_req = t.r1; m1_we = t.w1; m1_addr = t.a1; m1_wdata = t.d1;
    #2;

    rq[0] = t.r0; wq[0] = t.w0; aq[0] = t.a0; dq[0] = t.d0;
    rq[1] = t.r1; wq[1] = t.w1; aq[1] = t.a1; dq[1] = t.d1;
`ifdef DMEM_ARB_LOCK_EN
    lk[0] = m0_lock; lk[1] = m1_lock;
`else
    lk[0] = 1'b0; lk[1] = 1'b0;
`endif

    for (int x = 0; x < 2; x++) eg[x] = (mc == x) && rq[x];
    ewe = 1'b0; ea = '0; ed = '0;
    for (int x = 0; x < 2; x++) if (eg[x]) begin ewe = wq[x]; ea = aq[x]; ed = dq[x]; end

    check("gnt",      {m1_gnt, m0_gnt}, {eg[1], eg[0]});
    check("mem_we",   mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    check("mem_wd",   mem_wd, ed);
    check("rvalid",   {m1_rvalid, m0_rvalid}, {mrv[1], mrv[0]});
    if (mrv[0]) check("rdata0", m0_rdata, mrd[0]);
    if (mrv[1]) check("rdata1", m1_rdata, mrd[1]);
    if (t.chk) begin
      check("tbl_gnt",    {m1_gnt, m0_gnt}, {t.e_g1, t.e_g0});
      check("tbl_mem_we", mem_we, t.e_we);
      check("tbl_rvalid", {m1_rvalid, m0_rvalid}, {t.e_rv1, t.e_rv0});
      if (t.e_rv0) check("tbl_rdata0", m0_rdata, t.e_rd0);
    end
    act_g0 = m0_gnt;
    act_g1 = m1_gnt;

    // Effects of the coming clock edge.
    for (int x = 0; x < 2; x++) begin
      nrv[x] = eg[x] && !wq[x];
      if (nrv[x]) mrd[x] = mram[aq[x][7:2]];
    end
    // The RAM accepts a granted write even when reset is asserted.
    for (int x = 0; x < 2; x++) if (eg[x] && wq[x]) mram[aq[x][7:2]] = dq[x];

    if (!t.rn) begin
      mc = -1; mlock = -1; mlast = 1;
      for (int x = 0; x < 2; x++) begin mrv[x] = 1'b0; mrd[x] = '0; end
    end else begin
      for (int x = 0; x < 2; x++) mrv[x] = nrv[x];
      for (int x = 0; x < 2; x++) if (eg[x]) mlast = x;
      if (mc >= 0) begin
        y = mc;
        if (lk[y]) begin mlock = y; mc = -1; end
        else mc = rq[1-y] ? 1 - y : -1;
      end else if (mlock >= 0) begin
        y = mlock;
        if (rq[y]) begin mc = y; mlock = -1; end
        else if (!lk[y]) mlock = -1;
      end else begin
        if (rq[0] && rq[1]) mc = 1 - mlast;
        else if (rq[0])     mc = 0;
        else if (rq[1])     mc = 1;
        else                mc = -1;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t        tbl [18];
  logic        p_req [2], p_we [2];
  logic [31:0] p_a [2], p_d [2];
  vec_t        rv_t;

  initial begin
    for (int i = 0; i < 64; i++) mram[i] = '0;
    for (int x = 0; x < 2; x++) begin
      mrv[x] = 1'b0; mrd[x] = '0; eg[x] = 1'b0;
      p_req[x] = 1'b0; p_we[x] = 1'b0; p_a[x] = '0; p_d[x] = '0;
    end

    // Both-busy alternation, abandoned request, write/read-back.
    //           rn r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 we rv0 rv1 rd0
    tbl[0]  = v(0, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = v(1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24, 32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = v(1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24, 32'h0,        1, 0, 0, 0, 0, 32'h0);
    tbl[3]  = v(1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24, 32'h0,        0, 1, 0, 1, 0, 32'h0);
    tbl[4]  = v(1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24, 32'h0,        1, 0, 0, 0, 1, 32'h0);
    tbl[5]  = v(1, 1, 0, 32'h20, 32'h0,        1, 0, 32'h24, 32'h0,        0, 1, 0, 1, 0, 32'h0);
    tbl[6]  = v(1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0);
    tbl[7]  = v(1, 0, 0, 32'h0,  32'h0,        1, 1, 32'h30, 32'h11111111, 0, 0, 0, 0, 0, 32'h0);
    tbl[8]  = v(1, 0, 0, 32'h0,  32'h0,        0, 1, 32'h30, 32'h11111111, 0, 0, 0, 0, 0, 32'h0);
    tbl[9]  = v(1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[10] = v(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[11] = v(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        1, 0, 1, 0, 0, 32'h0);
    tbl[12] = v(1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[13] = v(1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0);
    tbl[14] = v(1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'hDEADBEEF);
    tbl[15] = v(1, 1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0);
    tbl[16] = v(1, 1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0);
    tbl[17] = v(1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h0);

    // Reset held with a pending M0 write; grant arrives at the second edge
    // after release.
    run_cycle(v(0, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(0, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h0));
    run_cycle(v(1, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));

    for (int i = 0; i < 18; i++) run_cycle(tbl[i]);

    // Reset during a read grant cancels rvalid.
    // Reset during a write grant still writes.
    // Arbitration restarts with M0 preferred.
    run_cycle(v(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(0, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0,  32'h0,  1, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 0, 0, 32'h0,  32'h0, 1, 1, 32'h50, 32'h55, 0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(0, 0, 0, 32'h0,  32'h0, 1, 1, 32'h50, 32'h55, 0, 1, 1, 0, 0, 32'h0));
    run_cycle(v(1, 1, 0, 32'h50, 32'h0, 1, 1, 32'h54, 32'h66, 0, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 1, 0, 32'h50, 32'h0, 1, 1, 32'h54, 32'h66, 1, 0, 0, 0, 0, 32'h0));
    run_cycle(v(1, 0, 0, 32'h0,  32'h0, 1, 1, 32'h54, 32'h66, 0, 1, 1, 1, 0, 32'h55));
    run_cycle(v(1, 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 32'h0));

    // Randomized traffic.
    // Each master holds a request stable until the model grants it, may
    // abandon it, and reset is pulsed occasionally.
    for (int c = 0; c < 600; c++) begin
      for (int x = 0; x < 2; x++) begin
        if (!p_req[x] && $urandom_range(0, 2) == 0) begin
          p_req[x] = 1'b1;
          p_we[x]  = 1'($urandom_range(0, 1));
          p_a[x]   = $urandom;
          p_d[x]   = $urandom;
        end else if (p_req[x] && $urandom_range(0, 15) == 0) begin
          p_req[x] = 1'b0;
        end
      end
`ifdef DMEM_ARB_LOCK_EN
      m0_lock = ($urandom_range(0, 3) == 0);
      m1_lock = ($urandom_range(0, 3) == 0);
`endif
      rv_t = v(1'($urandom_range(0, 49) != 0),
               p_req[0], p_we[0], p_a[0], p_d[0],
               p_req[1], p_we[1], p_a[1], p_d[1],
               0, 0, 0, 0, 0, 32'h0);
      rv_t.chk = 1'b0;
      run_cycle(rv_t);
      for (int x = 0; x < 2; x++) if (eg[x]) p_req[x] = 1'b0;
    end

`ifdef DMEM_ARB_LOCK_EN
    // M1 holds the lock over three reads while M0 keeps requesting.
    // M0 must follow shortly after the lock is released.
    begin
      int g1n = 0, g0_at = -1, g1_last_at = -1;
      m0_lock = 1'b0; m1_lock = 1'b0;
      run_cycle(v(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0));
      for (int c = 0; c < 20 && g0_at < 0; c++) begin
        m1_lock = (g1n < 2);
        rv_t = v(1, 1'(c > 0), 0, 32'h10, 32'h0, 1'(g1n < 3), 0, 32'h24, 32'h0,
                 0, 0, 0, 0, 0, 32'h0);
        rv_t.chk = 1'b0;
        run_cycle(rv_t);
        if (act_g1) begin g1n++; g1_last_at = c; end
        if (act_g0) g0_at = c;
      end
      check("lock_m1_first", 64'(g1n), 64'd3);
      check("lock_m0_soon", {63'd0, (g0_at >= 0) && (g0_at - g1_last_at <= 2)}, 64'd1);
      m1_lock = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
